// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM state encoding and requester ids.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CPU_OWN    = 2'd1,
        DBG_OWN    = 2'd2,
        DBG_LOCKED = 2'd3
    } arb_state_e;

    localparam logic RID_CPU = 1'b0;
    localparam logic RID_DBG = 1'b1;

    // Width of the debug anti-starvation counter; MAX_WAIT must fit (1..15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// One requester port of the data-memory arbiter (CPU load/store or debug/loader).
interface dmem_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  gnt;
    logic                  stall;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, stall, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, stall, rvalid, rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU port (priority) and the debug/loader port,
// with an anti-starvation counter and a debug burst lock.
//
//   state      | meaning
//   IDLE       | no owner; CPU has priority unless debug has waited MAX_WAIT cycles
//   CPU_OWN    | CPU was granted last cycle; same arbitration rules as IDLE
//   DBG_OWN    | debug was granted last cycle (single access); CPU retakes priority
//   DBG_LOCKED | debug burst: debug granted every cycle while dbg_lock, CPU stalled
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DM_DEPTH = 256,
    parameter int MAX_WAIT = 4,
    localparam int BE_W    = DATA_W / 8,
    localparam int IDX_W   = $clog2(DM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    dmem_req_if.slave         cpu,
    dmem_req_if.slave         dbg,
    input  logic              dbg_lock,
    output logic              addr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [IDX_W-1:0]  mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0]  MAX_WAIT_C = CNT_W'(MAX_WAIT);
    localparam logic [ADDR_W-3:0] DEPTH_C    = (ADDR_W-2)'(DM_DEPTH);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              rvalid_q, rvalid_d;
    logic              rsel_q, rsel_d;
    logic              rerr_q, rerr_d;

    logic              cpu_gnt_c, dbg_gnt_c, any_gnt;
    logic              force_dbg;
    logic              cpu_oor, dbg_oor;
    logic              win_we, win_oor;
    logic [BE_W-1:0]   win_be;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{cpu.addr[1:0], dbg.addr[1:0]};

    // Range check uses the full word address so indices beyond the memory are caught.
    assign cpu_oor   = cpu.addr[ADDR_W-1:2] >= DEPTH_C;
    assign dbg_oor   = dbg.addr[ADDR_W-1:2] >= DEPTH_C;
    assign force_dbg = dbg.req && (wait_cnt_q == MAX_WAIT_C);

    always_comb begin
        cpu_gnt_c = 1'b0;
        dbg_gnt_c = 1'b0;
        state_d   = state_q;
        case (state_q)
            DBG_LOCKED: begin
                if (dbg.req && dbg_lock) begin
                    dbg_gnt_c = 1'b1;
                    state_d   = DBG_LOCKED;
                end else begin
                    dbg_gnt_c = dbg.req && !cpu.req;
                    state_d   = IDLE;
                end
            end
            default: begin
                if (force_dbg || (dbg.req && !cpu.req)) begin
                    dbg_gnt_c = 1'b1;
                    state_d   = dbg_lock ? DBG_LOCKED : DBG_OWN;
                end else if (cpu.req) begin
                    cpu_gnt_c = 1'b1;
                    state_d   = CPU_OWN;
                end else begin
                    state_d   = IDLE;
                end
            end
        endcase
        // Nothing leaves the arbiter during the reset cycle.
        if (reset) begin
            cpu_gnt_c = 1'b0;
            dbg_gnt_c = 1'b0;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dbg.req || dbg_gnt_c) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        any_gnt   = cpu_gnt_c || dbg_gnt_c;
        win_we    = dbg_gnt_c ? dbg.we    : cpu.we;
        win_be    = dbg_gnt_c ? dbg.be    : cpu.be;
        win_addr  = dbg_gnt_c ? dbg.addr  : cpu.addr;
        win_wdata = dbg_gnt_c ? dbg.wdata : cpu.wdata;
        win_oor   = dbg_gnt_c ? dbg_oor   : cpu_oor;

        mem_en    = any_gnt && !win_oor;
        mem_we    = mem_en && win_we;
        mem_be    = mem_we ? win_be : '0;
        mem_addr  = mem_en ? win_addr[2 +: IDX_W] : '0;
        mem_wdata = mem_we ? win_wdata : '0;
        addr_err  = any_gnt && win_oor;

        rvalid_d  = any_gnt && !win_we;
        rsel_d    = dbg_gnt_c ? RID_DBG : RID_CPU;
        rerr_d    = win_oor;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            rvalid_q   <= 1'b0;
            rsel_q     <= RID_CPU;
            rerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rvalid_q   <= rvalid_d;
            rsel_q     <= rsel_d;
            rerr_q     <= rerr_d;
        end
    end

    always_comb begin
        cpu.gnt    = cpu_gnt_c;
        dbg.gnt    = dbg_gnt_c;
        cpu.stall  = !reset && cpu.req && !cpu_gnt_c;
        dbg.stall  = !reset && dbg.req && !dbg_gnt_c;
        cpu.rvalid = !reset && rvalid_q && (rsel_q == RID_CPU);
        dbg.rvalid = !reset && rvalid_q && (rsel_q == RID_DBG);
        // Out-of-range reads complete with zero data instead of stale memory output.
        cpu.rdata  = (cpu.rvalid && !rerr_q) ? mem_rdata : '0;
        dbg.rdata  = (dbg.rvalid && !rerr_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: grant timing checked per cycle, read returns via scoreboard.
module tb_dmem_port_arbiter;

    import dmem_arb_pkg::*;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        dbg_lock;
    logic        addr_err, mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] dmem [256];

    int checks = 0;
    int errors = 0;
    rsp_t exp_q[$];

    logic s_cg, s_cs, s_dg, s_en, s_err, s_crv, s_drv;
    logic [7:0] s_addr;

    dmem_req_if #(.ADDR_W(32), .DATA_W(32)) cpu_if ();
    dmem_req_if #(.ADDR_W(32), .DATA_W(32)) dbg_if ();

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DM_DEPTH(256), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (cpu_if.slave),
        .dbg       (dbg_if.slave),
        .dbg_lock  (dbg_lock),
        .addr_err  (addr_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 32'hA500_0000 | i;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) dmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= dmem[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented read return is matched against the oldest expectation.
    always @(negedge clk) begin
        if (cpu_if.rvalid || dbg_if.rvalid) begin
            if (cpu_if.rvalid && dbg_if.rvalid) begin
                chk("both_rvalid", 32'd1, 32'd0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {31'd0, dbg_if.rvalid}, 32'hFFFF_FFFF);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_port", {31'd0, dbg_if.rvalid}, {31'd0, e.port});
                chk("rsp_data", dbg_if.rvalid ? dbg_if.rdata : cpu_if.rdata, e.data);
                chk("rsp_other_zero", dbg_if.rvalid ? cpu_if.rdata : dbg_if.rdata, 32'd0);
            end
        end
    end

    task automatic drv_cpu(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        cpu_if.req = req; cpu_if.we = we; cpu_if.be = be; cpu_if.addr = addr; cpu_if.wdata = wdata;
    endtask

    task automatic drv_dbg(input logic req, input logic we, input logic lock,
                           input logic [31:0] addr, input logic [31:0] wdata);
        dbg_if.req = req; dbg_if.we = we; dbg_if.be = 4'hF; dbg_if.addr = addr;
        dbg_if.wdata = wdata; dbg_lock = lock;
    endtask

    task automatic idle();
        drv_cpu(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        drv_dbg(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Samples combinational outputs mid-cycle, then advances to just after the next edge.
    task automatic tick();
        @(negedge clk);
        s_cg = cpu_if.gnt; s_cs = cpu_if.stall; s_dg = dbg_if.gnt;
        s_en = mem_en; s_err = addr_err; s_addr = mem_addr;
        s_crv = cpu_if.rvalid; s_drv = dbg_if.rvalid;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic port, input logic [31:0] data);
        rsp_t r;
        r.port = port;
        r.data = data;
        exp_q.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        drv_cpu(1'b1, 1'b0, 4'hF, 32'h10, 32'd0);
        tick();
        chk("rst_cpu_gnt", {31'd0, s_cg}, 32'd0);
        chk("rst_cpu_stall", {31'd0, s_cs}, 32'd0);
        chk("rst_mem_en", {31'd0, s_en}, 32'd0);
        idle();
        tick();
        reset = 1'b0;
        idle();
        tick();
        chk("rst_state", {30'd0, dut.state_q}, {30'd0, IDLE});

        // Single CPU read of 0x10 -> word 4.
        drv_cpu(1'b1, 1'b0, 4'hF, 32'h10, 32'd0);
        push(RID_CPU, 32'hA500_0004);
        tick();
        chk("t1_cpu_gnt", {31'd0, s_cg}, 32'd1);
        chk("t1_mem_addr", {24'd0, s_addr}, 32'd4);
        chk("t1_stall", {31'd0, s_cs}, 32'd0);
        idle();
        tick();
        chk("t1_rvalid", {31'd0, s_crv}, 32'd1);

        // Anti-starvation: debug forced in on its 5th requesting cycle.
        drv_cpu(1'b1, 1'b0, 4'hF, 32'h20, 32'd0);
        drv_dbg(1'b1, 1'b0, 1'b0, 32'h24, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            push(RID_CPU, 32'hA500_0008);
            tick();
            chk($sformatf("t2_cpu_gnt_%0d", c), {31'd0, s_cg}, 32'd1);
            chk($sformatf("t2_dbg_gnt_%0d", c), {31'd0, s_dg}, 32'd0);
        end
        push(RID_DBG, 32'hA500_0009);
        tick();
        chk("t2_dbg_gnt_5", {31'd0, s_dg}, 32'd1);
        chk("t2_cpu_stall_5", {31'd0, s_cs}, 32'd1);
        chk("t2_wait_cnt", {28'd0, dut.wait_cnt_q}, 32'd0);
        drv_dbg(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        push(RID_CPU, 32'hA500_0008);
        tick();
        chk("t2_cpu_retake", {31'd0, s_cg}, 32'd1);
        chk("t2_cpu_nostall", {31'd0, s_cs}, 32'd0);
        idle();
        tick();

        // Locked debug burst of 8 writes while the CPU keeps a partial write pending.
        drv_cpu(1'b1, 1'b1, 4'b0011, 32'h80, 32'hC0C0_C0C0);
        drv_dbg(1'b1, 1'b1, 1'b1, 32'h0, 32'h1000_0000);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t3_cpu_first", {31'd0, s_cg}, 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            drv_dbg(1'b1, 1'b1, 1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i * 32'h111));
            tick();
            chk($sformatf("t3_dbg_gnt_%0d", i), {31'd0, s_dg}, 32'd1);
            chk($sformatf("t3_cpu_stall_%0d", i), {31'd0, s_cs}, 32'd1);
        end
        drv_dbg(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("t3_drop_cpu_gnt", {31'd0, s_cg}, 32'd0);
        tick();
        chk("t3_after_cpu_gnt", {31'd0, s_cg}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            drv_cpu(1'b1, 1'b0, 4'hF, 32'(4 * i), 32'd0);
            push(RID_CPU, 32'h1000_0000 + 32'(i * 32'h111));
            tick();
        end
        drv_cpu(1'b1, 1'b0, 4'hF, 32'h80, 32'd0);
        push(RID_CPU, 32'hA500_C0C0);
        tick();
        idle();
        tick();

        // Alternating single reads on consecutive cycles.
        drv_cpu(1'b1, 1'b0, 4'hF, 32'h40, 32'd0);
        push(RID_CPU, 32'hA500_0010);
        tick();
        chk("t4_cpu_gnt_a", {31'd0, s_cg}, 32'd1);
        drv_cpu(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        drv_dbg(1'b1, 1'b0, 1'b0, 32'h44, 32'd0);
        push(RID_DBG, 32'hA500_0011);
        tick();
        chk("t4_dbg_gnt_b", {31'd0, s_dg}, 32'd1);
        drv_dbg(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drv_cpu(1'b1, 1'b0, 4'hF, 32'h48, 32'd0);
        push(RID_CPU, 32'hA500_0012);
        tick();
        chk("t4_cpu_gnt_c", {31'd0, s_cg}, 32'd1);
        drv_cpu(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        drv_dbg(1'b1, 1'b0, 1'b0, 32'h4C, 32'd0);
        push(RID_DBG, 32'hA500_0013);
        tick();
        chk("t4_dbg_gnt_d", {31'd0, s_dg}, 32'd1);

        // Out-of-range debug read: index 256.
        drv_dbg(1'b1, 1'b0, 1'b0, 32'h400, 32'd0);
        push(RID_DBG, 32'd0);
        tick();
        chk("t5_dbg_gnt", {31'd0, s_dg}, 32'd1);
        chk("t5_addr_err", {31'd0, s_err}, 32'd1);
        chk("t5_mem_en", {31'd0, s_en}, 32'd0);
        idle();
        tick();
        chk("t5_dbg_rvalid", {31'd0, s_drv}, 32'd1);

        // Reset while locked with a debug read in flight: that read never returns.
        drv_dbg(1'b1, 1'b0, 1'b1, 32'h8, 32'd0);
        tick();
        chk("t6_dbg_gnt", {31'd0, s_dg}, 32'd1);
        drv_dbg(1'b1, 1'b0, 1'b1, 32'hC, 32'd0);
        reset = 1'b1;
        tick();
        chk("t6_rst_dbg_gnt", {31'd0, s_dg}, 32'd0);
        chk("t6_rst_rvalid", {31'd0, s_drv | s_crv}, 32'd0);
        reset = 1'b0;
        idle();
        tick();
        chk("t6_post_rvalid", {31'd0, s_drv | s_crv}, 32'd0);
        chk("t6_state", {30'd0, dut.state_q}, {30'd0, IDLE});
        drv_cpu(1'b1, 1'b0, 4'hF, 32'h0, 32'd0);
        push(RID_CPU, 32'h1000_0000);
        tick();
        chk("t6_cpu_gnt", {31'd0, s_cg}, 32'd1);
        idle();
        tick();
        tick();
        tick();
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
